// File: rtl/ptmch_pkg.sv
// +----------------------------------------------------------------------------+
// | ptmch_pkg : shared types, register map and SPI opcodes for the ptmch block  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package ptmch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int NUM_CH  = 5;
  localparam int NUM_WIN = 2 * NUM_CH;

  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_STATUS   = 5'h01;
  localparam logic [4:0] ADDR_HOLDOFF  = 5'h02;
  localparam logic [4:0] ADDR_COUNT    = 5'h03;
  localparam logic [4:0] ADDR_WIN_BASE = 5'h08;

  localparam int CH_PRGEXCT = 0;
  localparam int CH_RDSTAT  = 1;
  localparam int CH_BLKERS  = 2;
  localparam int CH_PDREAD  = 3;
  localparam int CH_WRSTAT  = 4;

  localparam logic [7:0] OP_PRGEXCT = 8'h10;
  localparam logic [7:0] OP_GETFEAT = 8'h0F;
  localparam logic [7:0] OP_RDSTAT  = 8'h05;
  localparam logic [7:0] OP_BLKERS  = 8'hD8;
  localparam logic [7:0] OP_PDREAD  = 8'h13;
  localparam logic [7:0] OP_SETFEAT = 8'h1F;
  localparam logic [7:0] OP_WRSTAT  = 8'h01;

  // Window i (LOW/HIGH interleaved, channel-major) lives at base + i.
  function automatic logic [4:0] win_addr(input int idx);
    return ADDR_WIN_BASE + 5'(idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptmch_trg_regs.sv
// +----------------------------------------------------------------------------+
// | ptmch_trg_regs : Avalon-MM decode, config storage and readback mux          |
// | Optional IRQ enable bit under PTMCH_TRG_CTRL_IRQ_EN.  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ptmch_trg_regs
  import ptmch_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int HOLDOFF_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [4:0]                   addr_i,
  input  logic                         write_i,
  input  logic [31:0]                  wdata_i,
  input  logic                         read_i,
  output logic [31:0]                  rdata_o,
  input  logic [1:0]                   state_i,
  input  logic [NUM_CH-1:0]            sticky_i,
  input  logic                         irq_pend_i,
  input  logic [CNT_W-1:0]             count_i,
  output logic [NUM_WIN-1:0][23:0]     win_o,
  output logic [NUM_CH-1:0]            mask_o,
  output logic                         cont_o,
  output logic [HOLDOFF_W-1:0]         holdoff_o,
  output logic                         irq_en_o,
  output logic                         arm_o,
  output logic                         disarm_o,
  output logic                         cnt_clr_o,
  output logic                         irq_clr_o
);

  logic [NUM_WIN-1:0][23:0] win_q;
  logic [NUM_CH-1:0]        mask_q;
  logic                     cont_q;
  logic [HOLDOFF_W-1:0]     holdoff_q;
  logic [31:0]              rdata_q;
  logic [31:0]              w_rd;
  logic                     w_wr_ctrl;
  logic                     unused_wdata;

  assign w_wr_ctrl = write_i && (addr_i == ADDR_CTRL);
  assign arm_o     = w_wr_ctrl && wdata_i[0];
  assign disarm_o  = w_wr_ctrl && wdata_i[2];
  assign cnt_clr_o = write_i && (addr_i == ADDR_COUNT);
  assign irq_clr_o = write_i && (addr_i == ADDR_STATUS) && wdata_i[16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q    <= '1;
      cont_q    <= 1'b0;
      holdoff_q <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        win_q[i] <= (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      end
    end else begin
      if (w_wr_ctrl) begin
        mask_q <= wdata_i[12:8];
        cont_q <= wdata_i[1];
      end
      if (write_i && (addr_i == ADDR_HOLDOFF)) begin
        holdoff_q <= wdata_i[HOLDOFF_W-1:0];
      end
      for (int i = 0; i < NUM_WIN; i++) begin
        if (write_i && (addr_i == win_addr(i))) begin
          win_q[i] <= wdata_i[23:0];
        end
      end
      rdata_q <= read_i ? w_rd : '0;
    end
  end

`ifdef PTMCH_TRG_CTRL_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
    end else if (w_wr_ctrl) begin
      irq_en_q <= wdata_i[3];
    end
  end

  assign irq_en_o     = irq_en_q;
  assign unused_wdata = ^wdata_i[31:24];
`else
  assign irq_en_o     = 1'b0;
  assign unused_wdata = ^{wdata_i[31:24], wdata_i[3]};
`endif

  always_comb begin
    w_rd = '0;
    case (addr_i)
      ADDR_CTRL: begin
        w_rd[12:8] = mask_q;
        w_rd[3]    = irq_en_o;
        w_rd[1]    = cont_q;
      end
      ADDR_STATUS: begin
        w_rd[1:0]  = state_i;
        w_rd[12:8] = sticky_i;
        w_rd[16]   = irq_pend_i;
      end
      ADDR_HOLDOFF: w_rd[HOLDOFF_W-1:0] = holdoff_q;
      ADDR_COUNT:   w_rd[CNT_W-1:0]     = count_i;
      default: begin
        for (int i = 0; i < NUM_WIN; i++) begin
          if (addr_i == win_addr(i)) begin
            w_rd[23:0] = win_q[i];
          end
        end
      end
    endcase
  end

  assign rdata_o   = rdata_q;
  assign win_o     = win_q;
  assign mask_o    = mask_q;
  assign cont_o    = cont_q;
  assign holdoff_o = holdoff_q;

endmodule

`default_nettype wire

// File: rtl/ptmch_trg_ctrl.sv
// +----------------------------------------------------------------------------+
// | ptmch_trg_ctrl : arm/hold-off FSM, hit counting and window outputs          |
// | Optional interrupt under PTMCH_TRG_CTRL_IRQ_EN.  Rev 1.0                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ptmch_trg_ctrl
  import ptmch_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int HOLDOFF_W = 16
) (
  input  logic        CLK160M,
  input  logic        RESET,
  input  logic [4:0]  AVS_ADDRESS,
  input  logic        AVS_WRITE,
  input  logic [31:0] AVS_WRITEDATA,
  input  logic        AVS_READ,
  output logic [31:0] AVS_READDATA,
  input  logic [4:0]  TRG_PLS,
  output logic [23:0] PRGEXCT_LOW_ADDR,
  output logic [23:0] PRGEXCT_HIGH_ADDR,
  output logic [23:0] RDSTAT_LOW_ADDR,
  output logic [23:0] RDSTAT_HIGH_ADDR,
  output logic [23:0] BLKERS_LOW_ADDR,
  output logic [23:0] BLKERS_HIGH_ADDR,
  output logic [23:0] PDREAD_LOW_ADDR,
  output logic [23:0] PDREAD_HIGH_ADDR,
  output logic [23:0] WRSTAT_LOW_ADDR,
  output logic [23:0] WRSTAT_HIGH_ADDR,
  output logic        TRG_OUT,
  output logic [4:0]  TRG_CH,
  output logic        IRQ
);

  logic [NUM_WIN-1:0][23:0] w_win;
  logic [NUM_CH-1:0]        w_mask;
  logic                     w_cont;
  logic [HOLDOFF_W-1:0]     w_holdoff;
  logic                     w_irq_en;
  logic                     w_arm;
  logic                     w_disarm;
  logic                     w_cnt_clr;
  logic                     w_irq_clr;
  logic                     w_irq_pend;

  state_e                   state_q,   state_d;
  logic [HOLDOFF_W-1:0]     timer_q,   timer_d;
  logic [NUM_CH-1:0]        sticky_q,  sticky_d;
  logic [CNT_W-1:0]         count_q,   count_d;
  logic [NUM_CH-1:0]        trg_ch_q,  trg_ch_d;
  logic                     trg_out_q, trg_out_d;
  logic [NUM_CH-1:0]        tp_1d_q;
  logic [NUM_CH-1:0]        w_hit;
  logic                     w_accept;

  ptmch_trg_regs #(
    .CNT_W     (CNT_W),
    .HOLDOFF_W (HOLDOFF_W)
  ) u_regs (
    .clk_i      (CLK160M),
    .rst_i      (RESET),
    .addr_i     (AVS_ADDRESS),
    .write_i    (AVS_WRITE),
    .wdata_i    (AVS_WRITEDATA),
    .read_i     (AVS_READ),
    .rdata_o    (AVS_READDATA),
    .state_i    (state_q),
    .sticky_i   (sticky_q),
    .irq_pend_i (w_irq_pend),
    .count_i    (count_q),
    .win_o      (w_win),
    .mask_o     (w_mask),
    .cont_o     (w_cont),
    .holdoff_o  (w_holdoff),
    .irq_en_o   (w_irq_en),
    .arm_o      (w_arm),
    .disarm_o   (w_disarm),
    .cnt_clr_o  (w_cnt_clr),
    .irq_clr_o  (w_irq_clr)
  );

  assign PRGEXCT_LOW_ADDR  = w_win[2*CH_PRGEXCT];
  assign PRGEXCT_HIGH_ADDR = w_win[2*CH_PRGEXCT+1];
  assign RDSTAT_LOW_ADDR   = w_win[2*CH_RDSTAT];
  assign RDSTAT_HIGH_ADDR  = w_win[2*CH_RDSTAT+1];
  assign BLKERS_LOW_ADDR   = w_win[2*CH_BLKERS];
  assign BLKERS_HIGH_ADDR  = w_win[2*CH_BLKERS+1];
  assign PDREAD_LOW_ADDR   = w_win[2*CH_PDREAD];
  assign PDREAD_HIGH_ADDR  = w_win[2*CH_PDREAD+1];
  assign WRSTAT_LOW_ADDR   = w_win[2*CH_WRSTAT];
  assign WRSTAT_HIGH_ADDR  = w_win[2*CH_WRSTAT+1];

  // Rising-edge detect gives one hit per stretched pulse; ARM/DISARM pre-empt it.
  assign w_hit    = TRG_PLS & ~tp_1d_q & w_mask;
  assign w_accept = (state_q == ARMED) && (|w_hit) && !w_arm && !w_disarm;

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sticky_q  <= '0;
      count_q   <= '0;
      trg_ch_q  <= '0;
      trg_out_q <= 1'b0;
      tp_1d_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
      trg_ch_q  <= trg_ch_d;
      trg_out_q <= trg_out_d;
      tp_1d_q   <= TRG_PLS;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sticky_d  = sticky_q;
    count_d   = count_q;
    trg_ch_d  = trg_ch_q;
    trg_out_d = w_accept;

    if (w_disarm) begin
      state_d = IDLE;
    end else if (w_arm) begin
      state_d  = ARMED;
      timer_d  = '0;
      sticky_d = '0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (w_accept) begin
            sticky_d = sticky_q | w_hit;
            if (!w_cont) begin
              state_d = DONE;
            end else if (w_holdoff != '0) begin
              state_d = HOLDOFF;
              timer_d = w_holdoff;
            end
          end
        end
        HOLDOFF: begin
          // Leaving on timer==1 blocks exactly N cycles after the hit cycle.
          timer_d = timer_q - HOLDOFF_W'(1);
          if (timer_q <= HOLDOFF_W'(1)) begin
            state_d = ARMED;
            timer_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (w_accept) begin
      trg_ch_d = w_hit;
    end

    if (w_cnt_clr) begin
      count_d = '0;
    end else if (w_accept && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign TRG_OUT = trg_out_q;
  assign TRG_CH  = trg_ch_q;

`ifdef PTMCH_TRG_CTRL_IRQ_EN
  logic irq_pend_q;

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      irq_pend_q <= 1'b0;
    end else if (w_accept) begin
      irq_pend_q <= 1'b1;
    end else if (w_irq_clr) begin
      irq_pend_q <= 1'b0;
    end
  end

  assign w_irq_pend = irq_pend_q;
  assign IRQ        = irq_pend_q & w_irq_en;
`else
  logic unused_irq;

  assign w_irq_pend = 1'b0;
  assign IRQ        = 1'b0;
  assign unused_irq = ^{w_irq_clr, w_irq_en};
`endif

endmodule

`default_nettype wire

// File: doc/ptmch_trg_ctrl.md
Name: ptmch_trg_ctrl

Overview:
- Control/status block for the SPI pattern-match trigger datapath (5 instruction channels: program-execute, read-status, 128KB block-erase, page-data-read, write-status).
- Holds the ten 24-bit page-address window registers that drive the trigger's address inputs.
- Arms and disarms triggering, masks channels, and applies a post-hit hold-off.
- Counts and latches hits. Sits between the Avalon-MM system bus and the trigger datapath, in the CLK160M domain.

Parameters:
- CNT_W, 16, width of the saturating hit counter
- HOLDOFF_W, 16, width of the hold-off register and timer

Ports:
- CLK160M  in  1  system clock; the only clock
- RESET  in  1  synchronous, active-high reset
- AVS_ADDRESS  in  5  word address
- AVS_WRITE  in  1  write strobe
- AVS_WRITEDATA  in  32  write data
- AVS_READ  in  1  read strobe
- AVS_READDATA  out  32  read data, 1-cycle latency
- TRG_PLS  in  5  stretched trigger pulses from the trigger datapath, same clock
- PRGEXCT_LOW_ADDR / PRGEXCT_HIGH_ADDR  out  24 each  window, channel 0
- RDSTAT_LOW_ADDR / RDSTAT_HIGH_ADDR  out  24 each  window, channel 1
- BLKERS_LOW_ADDR / BLKERS_HIGH_ADDR  out  24 each  window, channel 2
- PDREAD_LOW_ADDR / PDREAD_HIGH_ADDR  out  24 each  window, channel 3
- WRSTAT_LOW_ADDR / WRSTAT_HIGH_ADDR  out  24 each  window, channel 4
- TRG_OUT  out  1  one-cycle qualified trigger strobe
- TRG_CH  out  5  channel(s) of the last accepted hit, registered
- IRQ  out  1  interrupt; see optional feature

Behaviour:
- Clock and reset: one clock, CLK160M. RESET is synchronous and active-high; all state is updated on the CLK160M rising edge.
- Reset values:
  - all LOW windows 24'h000000; all HIGH windows 24'hFFFFFF
  - MASK 5'h1F, CONT 0, HOLDOFF 0, count 0
  - state IDLE; TRG_OUT, TRG_CH, IRQ, AVS_READDATA all 0
- Register map (word addresses):
  - 0x00 CTRL: [0] ARM (write-1 pulse), [1] CONT, [2] DISARM (write-1 pulse), [12:8] MASK. Reads return CONT and MASK; ARM and DISARM read 0.
  - 0x01 STATUS (RO): [1:0] state (IDLE=0, ARMED=1, HOLDOFF=2, DONE=3), [12:8] sticky latched hits, [16] IRQ pending.
  - 0x02 HOLDOFF: [HOLDOFF_W-1:0].
  - 0x03 COUNT: read returns the count; any write clears it.
  - 0x08–0x11 windows, LOW then HIGH, channel order 0..4, bits [23:0].
  - Undefined addresses read 0; writes to them are ignored.
- Window, MASK and CONT writes take effect on the next cycle, in any state. Window registers drive the window outputs directly, with no shadowing.
- Hit detect: TRG_PLS is registered once to form tp_1d. hit = TRG_PLS & ~tp_1d & MASK. This gives one hit per stretched pulse. Latency from the TRG_PLS rising edge to TRG_OUT is 1 cycle.
- FSM:
  - IDLE: ignores hits. ARM → ARMED; the sticky hits are cleared on that transition.
  - ARMED, on |hit:
    - TRG_OUT=1 for 1 cycle; TRG_CH=hit; sticky |= hit; count++.
    - Next state: CONT=0 → DONE. CONT=1 and HOLDOFF=0 → stay ARMED. CONT=1 and HOLDOFF=N>0 → HOLDOFF, timer loaded with N.
  - HOLDOFF: timer decrements each cycle; hits are ignored and not counted. When the timer is 1, next state is ARMED. Hits are therefore blocked for exactly N cycles after the hit cycle.
  - DONE: ignores hits. ARM → ARMED, clearing the sticky hits. DISARM → IDLE.
- Priority:
  - DISARM beats ARM when both are written in one cycle.
  - DISARM beats a simultaneous hit: no TRG_OUT, no count; next state IDLE.
  - ARM while already ARMED or in HOLDOFF restarts at ARMED and clears the sticky hits and the timer.
- Multiple channels hitting in one cycle give one TRG_OUT, TRG_CH carrying all of them, and count +1.
- Counter saturates at all-ones; no wrap.
- COUNT-clear write in the same cycle as a hit leaves count 0 (clear wins).
- Reset mid-operation returns every register to its reset value on the next edge; no pulse is emitted.

Optional Feature:
- Macro: PTMCH_TRG_CTRL_IRQ_EN.
- Defined:
  - IRQ pending sets on every accepted hit.
  - Writing 0x01 with bit16=1 clears it; set wins over a simultaneous clear.
  - IRQ = pending & CTRL[3] (IRQ enable, R/W, reset 0).
- Undefined: IRQ is tied 0, CTRL[3] reads 0, STATUS[16] reads 0.

Decomposition:
- Package ptmch_pkg:
  - state enum: IDLE, ARMED, HOLDOFF, DONE
  - register address localparams
  - channel index constants (CH_PRGEXCT=0 … CH_WRSTAT=4)
  - SPI opcode constants (8'h10, 8'h0F, 8'h05, 8'hD8, 8'h13, 8'h1F, 8'h01), shared with the trigger datapath
- One sub-module, ptmch_trg_regs: bus decode, window/CTRL/HOLDOFF storage, readback mux. It emits arm/disarm/clear pulses to the FSM in the top.

Test Plan:
- After RESET: read 0x09 → 0x00FFFFFF; read 0x00 → 0x00001F00; window outputs are LOW 0 / HIGH FFFFFF.
- Write 0x00=1 (single mode, ARM); pulse TRG_PLS=5'b00100 for 15 cycles → one TRG_OUT exactly 1 cycle after the edge, TRG_CH=00100, STATUS=0x00000403, COUNT=1; a second pulse is ignored.
- CONT=1, HOLDOFF=20, edges at t and t+10 and t+25 → TRG_OUT at t+1 and t+26 only; COUNT=2.
- MASK=5'b00001; pulse channel 3 → no TRG_OUT; pulse channel 0 → TRG_OUT.
- Same-cycle DISARM write and TRG_PLS edge → no TRG_OUT, state IDLE, COUNT unchanged.
- Force count to all-ones by repeated pulses, then one more hit → COUNT stays 0xFFFF. Write 0x03 in the same cycle as a hit → COUNT reads 0.
